// File: rtl/position_encoder.sv
// Keypad cell-select encoder: sync, debounce, single-press filter, release wait, valid/ready output.
// Optional ILLEGAL_MOVE_CHECK_EN rejects presses on occupied cells with a one-cycle illegal pulse.
//
// state    | meaning
// IDLE     | waiting for exactly one synchronized button
// DEBOUNCE | candidate button must stay stable for DEBOUNCE_CYCLES samples
// VALID    | pos_out presented, waiting for pos_ready
// RELEASE  | all buttons must read released for DEBOUNCE_CYCLES samples
module position_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] btn,
  input  logic [8:0] occupied,
  input  logic       pos_ready,
  output logic [3:0] pos_out,
  output logic       pos_valid,
  output logic       illegal,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, VALID, RELEASE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_nxt;
  logic [8:0]       btn_q1, btn_s;
  logic [8:0]       cand, cand_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       pos_nxt;
  logic             valid_nxt;
  logic             illegal_q, illegal_nxt;
  logic             btn_onehot;
  logic             reject;

  function automatic logic [3:0] encode(input logic [8:0] oh);
    logic [3:0] enc;
    enc = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (oh[i]) enc = 4'(i + 1);
    end
    return enc;
  endfunction

  assign btn_onehot = (btn_s != 9'd0) && ((btn_s & (btn_s - 9'd1)) == 9'd0);

`ifdef ILLEGAL_MOVE_CHECK_EN
  assign reject  = (occupied & cand) != 9'd0;
  assign illegal = illegal_q;
`else
  logic unused_occupied;
  assign unused_occupied = ^{occupied, illegal_q};
  assign reject  = 1'b0;
  assign illegal = 1'b0;
`endif

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    cand_nxt    = cand;
    cnt_nxt     = cnt;
    pos_nxt     = pos_out;
    valid_nxt   = pos_valid;
    illegal_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (btn_onehot) begin
          cand_nxt  = btn_s;
          cnt_nxt   = CNT_ONE;
          state_nxt = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (btn_s != cand) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          cnt_nxt = '0;
          if (reject) begin
            illegal_nxt = 1'b1;
            state_nxt   = RELEASE;
          end else begin
            pos_nxt   = encode(cand);
            valid_nxt = 1'b1;
            state_nxt = VALID;
          end
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      VALID: begin
        if (pos_ready) begin
          valid_nxt = 1'b0;
          cnt_nxt   = '0;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (btn_s != 9'd0) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      btn_q1    <= '0;
      btn_s     <= '0;
      cand      <= '0;
      cnt       <= '0;
      pos_out   <= '0;
      pos_valid <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      btn_q1    <= btn;
      btn_s     <= btn_q1;
      cand      <= cand_nxt;
      cnt       <= cnt_nxt;
      pos_out   <= pos_nxt;
      pos_valid <= valid_nxt;
      illegal_q <= illegal_nxt;
    end
  end

endmodule

// File: tb/tb_position_encoder.sv
// Directed bench for position_encoder: table of single presses plus hand sequences for
// hold, handshake, release, multi-press abort, bounce and mid-handshake reset.
module tb_position_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] btn;
  logic [8:0] occupied;
  logic       pos_ready;
  logic [3:0] pos_out;
  logic       pos_valid;
  logic       illegal;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  position_encoder #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .occupied(occupied), .pos_ready(pos_ready),
    .pos_out(pos_out), .pos_valid(pos_valid), .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] btn;
    logic [8:0] occ;
    logic [3:0] exp_pos;
    logic       exp_valid;
    logic       exp_illegal;
  } vec_t;

  vec_t vecs[10];

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 30) begin
      tick(1);
      n++;
    end
    check(name, busy, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic handshake(input string name);
    pos_ready = 1'b1;
    tick(1);
    pos_ready = 1'b0;
    check(name, pos_valid, 0);
  endtask

  initial begin
    logic bounce_seen;
    rst_n = 1'b0; btn = '0; occupied = '0; pos_ready = 1'b0;

    vecs[0] = '{9'h010, 9'h000, 4'd5, 1'b1, 1'b0};
    vecs[1] = '{9'h001, 9'h000, 4'd1, 1'b1, 1'b0};
    vecs[2] = '{9'h100, 9'h000, 4'd9, 1'b1, 1'b0};
`ifdef ILLEGAL_MOVE_CHECK_EN
    vecs[3] = '{9'h004, 9'h004, 4'd9, 1'b0, 1'b1};
    vecs[4] = '{9'h005, 9'h000, 4'd9, 1'b0, 1'b0};
`else
    vecs[3] = '{9'h004, 9'h004, 4'd3, 1'b1, 1'b0};
    vecs[4] = '{9'h005, 9'h000, 4'd3, 1'b0, 1'b0};
`endif
    vecs[5] = '{9'h020, 9'h010, 4'd6, 1'b1, 1'b0};
    vecs[6] = '{9'h002, 9'h000, 4'd2, 1'b1, 1'b0};
    vecs[7] = '{9'h008, 9'h000, 4'd4, 1'b1, 1'b0};
    vecs[8] = '{9'h040, 9'h000, 4'd7, 1'b1, 1'b0};
    vecs[9] = '{9'h080, 9'h000, 4'd8, 1'b1, 1'b0};

    tick(2);
    check("reset_pos_out", pos_out, 0);
    check("reset_pos_valid", pos_valid, 0);
    check("reset_illegal", illegal, 0);
    check("reset_busy", busy, 0);
    rst_n = 1'b1;
    tick(1);

    foreach (vecs[k]) begin
      btn = vecs[k].btn;
      occupied = vecs[k].occ;
      tick(5);
      check($sformatf("vec%0d_early_valid", k), pos_valid, 0);
      check($sformatf("vec%0d_early_illegal", k), illegal, 0);
      tick(1);
      check($sformatf("vec%0d_valid", k), pos_valid, vecs[k].exp_valid);
      check($sformatf("vec%0d_illegal", k), illegal, vecs[k].exp_illegal);
      check($sformatf("vec%0d_pos_out", k), pos_out, vecs[k].exp_pos);
      if (vecs[k].exp_illegal) begin
        tick(1);
        check($sformatf("vec%0d_illegal_width", k), illegal, 0);
        check($sformatf("vec%0d_no_valid", k), pos_valid, 0);
      end
      if (vecs[k].exp_valid) handshake($sformatf("vec%0d_handshake", k));
      btn = '0;
      occupied = '0;
      wait_idle($sformatf("vec%0d_idle", k));
      tick(1);
    end

    // Hold a press with pos_ready low: output must stay put.
    btn = 9'h010;
    tick(6);
    check("hold_valid", pos_valid, 1);
    check("hold_pos", pos_out, 5);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("hold_stable", {pos_valid, pos_out}, {1'b1, 4'd5});
    end
    handshake("hold_handshake");
    tick(10);
    check("held_no_revalid", pos_valid, 0);
    check("held_busy", busy, 1);
    btn = '0;
    tick(5);
    check("release_not_done", busy, 1);
    tick(1);
    check("release_done", busy, 0);
    btn = 9'h100;
    tick(6);
    check("cell9_valid", pos_valid, 1);
    check("cell9_pos", pos_out, 9);
    handshake("cell9_handshake");
    btn = '0;
    wait_idle("cell9_idle");

    // Second button added during debounce aborts the press.
    do_reset();
    btn = 9'h001;
    tick(3);
    btn = 9'h005;
    tick(10);
    check("multi_valid", pos_valid, 0);
    check("multi_busy", busy, 0);
    check("multi_pos", pos_out, 0);
    btn = '0;
    tick(4);

    // Bounce on cell 2, then a stable press.
    bounce_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      btn = 9'h002;
      for (int j = 0; j < 2; j++) begin tick(1); if (pos_valid) bounce_seen = 1'b1; end
      btn = 9'h000;
      for (int j = 0; j < 2; j++) begin tick(1); if (pos_valid) bounce_seen = 1'b1; end
    end
    check("bounce_no_valid", bounce_seen, 0);
    btn = 9'h002;
    tick(5);
    check("bounce_early", pos_valid, 0);
    tick(1);
    check("bounce_valid", pos_valid, 1);
    check("bounce_pos", pos_out, 2);
    handshake("bounce_handshake");
    tick(10);
    check("bounce_single", pos_valid, 0);
    btn = '0;
    wait_idle("bounce_idle");

    // Reset in the middle of a handshake.
    btn = 9'h040;
    tick(6);
    check("prereset_pos", pos_out, 7);
    check("prereset_valid", pos_valid, 1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check("midreset_pos", pos_out, 0);
    check("midreset_valid", pos_valid, 0);
    check("midreset_busy", busy, 0);
    btn = '0;
    tick(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
